// File: rtl/rx_char_assembler.sv
// ---------------------------------------------------------------------------
// rx_char_assembler
//
// Receive-path character framer. It sits directly behind the bit-sample
// counter and consumes one mid-bit sampled bit per bit_valid strobe. It frames
// start / data / optional parity / stop bits, assembles the character
// LSB-first, and presents it through a one-deep valid/ready output buffer.
//
// Parameters
//   DATA_BITS  : data bits per character (5..8)
//   PARITY_EN  : 1 = a parity bit follows the data bits
//   PARITY_ODD : 0 = even parity, 1 = odd parity (unused when PARITY_EN=0)
//
// Ports
//   clk        : system clock
//   rst        : synchronous, active-low reset
//   bit_valid  : one-cycle strobe, bit_data holds a new sampled bit
//   bit_data   : sampled serial bit value
//   char_data  : assembled character, LSB = first data bit received
//   char_valid : char_data holds an unconsumed character
//   char_ready : consumer accepts char_data when char_valid && char_ready
//   frame_err  : one-cycle pulse, stop bit sampled as 0
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : sticky, a good character was dropped (buffer full)
//   ovr_clr    : clears overrun
//   busy       : high while a frame is in progress
// ---------------------------------------------------------------------------
module rx_char_assembler #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic [DATA_BITS-1:0] char_data,
  output logic                 char_valid,
  input  logic                 char_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state_reg,  state_next;
  logic [CW-1:0]        cnt_reg,    cnt_next;
  logic [DATA_BITS-1:0] shreg_reg,  shreg_next;
  logic                 par_reg,    par_next;
  logic [DATA_BITS-1:0] data_reg,   data_next;
  logic                 valid_reg,  valid_next;
  logic                 ferr_reg,   ferr_next;
  logic                 perr_reg,   perr_next;
  logic                 ovr_reg,    ovr_next;
  logic                 good;
  logic                 par_exp;

  // Parity bit the transmitter should have sent for the assembled data.
  assign par_exp = (PARITY_ODD != 0) ? ~(^shreg_reg) : (^shreg_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      par_reg   <= 1'b0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      perr_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      par_reg   <= par_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      perr_reg  <= perr_next;
      ovr_reg   <= ovr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    par_next   = par_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ferr_next  = 1'b0;
    perr_next  = 1'b0;
    ovr_next   = ovr_reg;
    good       = 1'b0;

    // Handshake: the held character leaves the buffer on char_ready.
    if (valid_reg && char_ready) begin
      valid_next = 1'b0;
    end

    // Clear first so that a same-cycle overrun below overrides it.
    if (ovr_clr) begin
      ovr_next = 1'b0;
    end

    if (bit_valid) begin
      case (state_reg)
        IDLE: begin
          // A 1 on an idle line is just the line resting high.
          if (!bit_data) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          // Shift right so the first data bit ends up in bit 0.
          shreg_next = {bit_data, shreg_reg[DATA_BITS-1:1]};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_next   = bit_data;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // Framing takes precedence over parity when both are wrong.
          if (!bit_data) begin
            ferr_next = 1'b1;
          end else if ((PARITY_EN != 0) && (par_reg != par_exp)) begin
            perr_next = 1'b1;
          end else begin
            good = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Load if the buffer is empty or is being drained this very cycle;
    // otherwise the new character is dropped and the old one kept.
    if (good) begin
      if (!valid_reg || char_ready) begin
        data_next  = shreg_reg;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end
  end

  assign char_data  = data_reg;
  assign char_valid = valid_reg;
  assign frame_err  = ferr_reg;
  assign parity_err = perr_reg;
  assign overrun    = ovr_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_char_assembler.sv
// ---------------------------------------------------------------------------
// tb_rx_char_assembler
//
// Bench for rx_char_assembler. Two instances: u_np (no parity) and u_p
// (even parity). The strobe stream is steered to one of them by sel.
// Expected characters are pushed to a queue when a good frame is driven and
// popped when the character is consumed through the output handshake.
// ---------------------------------------------------------------------------
module tb_rx_char_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b1;
  logic       char_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       sel = 1'b0;

  logic       bv_np, bv_p;
  logic [7:0] cd_np, cd_p;
  logic       cv_np, cv_p;
  logic       fe_np, fe_p;
  logic       pe_np, pe_p;
  logic       ov_np, ov_p;
  logic       by_np, by_p;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  assign bv_np = bit_valid & ~sel;
  assign bv_p  = bit_valid &  sel;

  always #5 clk = ~clk;

  rx_char_assembler #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .rst(rst), .bit_valid(bv_np), .bit_data(bit_data),
    .char_data(cd_np), .char_valid(cv_np), .char_ready(char_ready),
    .frame_err(fe_np), .parity_err(pe_np), .overrun(ov_np),
    .ovr_clr(ovr_clr), .busy(by_np)
  );

  rx_char_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .rst(rst), .bit_valid(bv_p), .bit_data(bit_data),
    .char_data(cd_p), .char_valid(cv_p), .char_ready(char_ready),
    .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p),
    .ovr_clr(ovr_clr), .busy(by_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    bit_valid = 1'b1;
    bit_data  = b;
    tick();
    bit_valid = 1'b0;
    bit_data  = 1'b1;
    repeat (gap) tick();
  endtask

  // Full frame; returns 1 ns after the edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int gap, input logic ready_at_stop);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    if (sel) strobe(par, gap);
    char_ready = ready_at_stop;
    strobe(stop, 0);
    char_ready = 1'b0;
    $display("frame sel=%0d data=0x%02h par=%0d stop=%0d", sel, d, par, stop);
  endtask

  // Pop the expected character, compare it, drain it, check buffer empties.
  task automatic consume(input string name);
    logic [7:0] e;
    logic [7:0] got;
    logic       v;
    e   = exp_q.pop_front();
    got = sel ? cd_p : cd_np;
    v   = sel ? cv_p : cv_np;
    n_checks++;
    if (v !== 1'b1) begin
      n_errors++; $display("FAIL %s char_valid: got %0b want 1", name, v);
    end
    n_checks++;
    if (got !== e) begin
      n_errors++; $display("FAIL %s char_data: got 0x%02h want 0x%02h", name, got, e);
    end
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    v = sel ? cv_p : cv_np;
    n_checks++;
    if (v !== 1'b0) begin
      n_errors++; $display("FAIL %s valid after handshake: got %0b want 0", name, v);
    end
    $display("consume %s data=0x%02h expected=0x%02h", name, got, e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({cd_np, cv_np, fe_np, pe_np, ov_np, by_np} !== 13'd0) begin
      n_errors++; $display("FAIL reset_np outputs: got %b want 0", {cd_np, cv_np, fe_np, pe_np, ov_np, by_np});
    end
    n_checks++;
    if ({cd_p, cv_p, fe_p, pe_p, ov_p, by_p} !== 13'd0) begin
      n_errors++; $display("FAIL reset_p outputs: got %b want 0", {cd_p, cv_p, fe_p, pe_p, ov_p, by_p});
    end
    rst = 1'b1;
    tick();
    $display("reset done");
  endtask

  task automatic test_basic();
    sel = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
    exp_q.push_back(8'hA5);
    n_checks++;
    if (by_np !== 1'b0) begin
      n_errors++; $display("FAIL basic busy: got %0b want 0", by_np);
    end
    // Must hold while char_ready stays low.
    repeat (3) tick();
    n_checks++;
    if (cv_np !== 1'b1 || cd_np !== 8'hA5) begin
      n_errors++; $display("FAIL basic hold: got v=%0b d=0x%02h want v=1 d=0xa5", cv_np, cd_np);
    end
    consume("basic");
  endtask

  task automatic test_frame_err();
    sel = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
    n_checks++;
    if (fe_np !== 1'b1 || cv_np !== 1'b0 || by_np !== 1'b0) begin
      n_errors++; $display("FAIL frame_err pulse: got fe=%0b v=%0b busy=%0b want 1 0 0", fe_np, cv_np, by_np);
    end
    tick();
    n_checks++;
    if (fe_np !== 1'b0 || cv_np !== 1'b0) begin
      n_errors++; $display("FAIL frame_err width: got fe=%0b v=%0b want 0 0", fe_np, cv_np);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h5A);
    consume("after_frame_err");
  endtask

  task automatic test_overrun();
    sel = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0);   // dropped: buffer full
    n_checks++;
    if (ov_np !== 1'b1 || cd_np !== exp_q[0] || cv_np !== 1'b1) begin
      n_errors++; $display("FAIL overrun set: got ov=%0b d=0x%02h v=%0b want 1 0x%02h 1", ov_np, cd_np, cv_np, exp_q[0]);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_checks++;
    if (ov_np !== 1'b0 || cd_np !== exp_q[0]) begin
      n_errors++; $display("FAIL overrun clear: got ov=%0b d=0x%02h want 0 0x%02h", ov_np, cd_np, exp_q[0]);
    end
    // Old character drains on the same edge the new one loads.
    send_frame(8'h22, 1'b0, 1'b1, 1, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h22);
    n_checks++;
    if (ov_np !== 1'b0 || cv_np !== 1'b1 || cd_np !== 8'h22) begin
      n_errors++; $display("FAIL simultaneous: got ov=%0b v=%0b d=0x%02h want 0 1 0x22", ov_np, cv_np, cd_np);
    end
    consume("simultaneous");
    // Set wins over a same-cycle clear.
    send_frame(8'h33, 1'b0, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h33);
    send_frame(8'h44, 1'b0, 1'b0, 1, 1'b0);   // frame error: never an overrun
    n_checks++;
    if (ov_np !== 1'b0 || fe_np !== 1'b1) begin
      n_errors++; $display("FAIL ferr_no_ovr: got ov=%0b fe=%0b want 0 1", ov_np, fe_np);
    end
    ovr_clr = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1, 1, 1'b0);
    ovr_clr = 1'b0;
    n_checks++;
    if (ov_np !== 1'b1 || cd_np !== 8'h33) begin
      n_errors++; $display("FAIL set_wins: got ov=%0b d=0x%02h want 1 0x33", ov_np, cd_np);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    consume("after_set_wins");
  endtask

  task automatic test_parity();
    sel = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h07);
    n_checks++;
    if (pe_p !== 1'b0 || fe_p !== 1'b0) begin
      n_errors++; $display("FAIL parity_ok err: got pe=%0b fe=%0b want 0 0", pe_p, fe_p);
    end
    consume("parity_ok");
    send_frame(8'h07, 1'b0, 1'b1, 1, 1'b0);
    n_checks++;
    if (pe_p !== 1'b1 || cv_p !== 1'b0) begin
      n_errors++; $display("FAIL parity_bad pulse: got pe=%0b v=%0b want 1 0", pe_p, cv_p);
    end
    tick();
    n_checks++;
    if (pe_p !== 1'b0 || cv_p !== 1'b0) begin
      n_errors++; $display("FAIL parity_bad width: got pe=%0b v=%0b want 0 0", pe_p, cv_p);
    end
    // Bad parity and bad stop together: only the framing error reports.
    send_frame(8'h07, 1'b0, 1'b0, 1, 1'b0);
    n_checks++;
    if (fe_p !== 1'b1 || pe_p !== 1'b0 || cv_p !== 1'b0) begin
      n_errors++; $display("FAIL both_err: got fe=%0b pe=%0b v=%0b want 1 0 0", fe_p, pe_p, cv_p);
    end
    send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);   // four ones, even parity bit 0
    exp_q.push_back(8'hC3);
    consume("parity_c3");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    strobe(1'b0, 1);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1);
    n_checks++;
    if (by_np !== 1'b1) begin
      n_errors++; $display("FAIL mid busy: got %0b want 1", by_np);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({cd_np, cv_np, fe_np, pe_np, ov_np, by_np} !== 13'd0) begin
      n_errors++; $display("FAIL mid reset outputs: got %b want 0", {cd_np, cv_np, fe_np, pe_np, ov_np, by_np});
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1);
    n_checks++;
    if (by_np !== 1'b0 || cv_np !== 1'b0) begin
      n_errors++; $display("FAIL mid leftovers: got busy=%0b v=%0b want 0 0", by_np, cv_np);
    end
    send_frame(8'h81, 1'b0, 1'b1, 1, 1'b0);
    exp_q.push_back(8'h81);
    consume("after_mid_reset");
  endtask

  task automatic test_idle_spacing();
    int bad;
    sel = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, i % 2);
      if (by_np !== 1'b0 || cv_np !== 1'b0 || fe_np !== 1'b0 || ov_np !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL idle strobes: got %0d disturbed cycles want 0", bad);
    end
    send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0);
    exp_q.push_back(8'hFF);
    consume("back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_overrun();
    test_parity();
    test_reset_mid();
    test_idle_spacing();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
